// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU byte bus: byte RAM plus an I/O page with
// a TX FIFO, status register, coherent cycle-counter snapshot and halt flag.
module mem_bus_responder #(
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        rdy_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt_o,
  output logic [31:0] cycle_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [3:0] OFF_TX    = 4'h0;
  localparam logic [3:0] OFF_STAT  = 4'h4;
  localparam logic [3:0] OFF_CNT_0 = 4'h8;
  localparam logic [3:0] OFF_CNT_1 = 4'h9;
  localparam logic [3:0] OFF_CNT_2 = 4'hA;
  localparam logic [3:0] OFF_CNT_3 = 4'hB;

  logic [7:0]        ram [0:(2**ADDR_W)-1];
  logic [7:0]        fifo_mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       cnt_snap;

  logic              io_sel, full, empty, wr_ok, push, pop, halt_wr;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        off;
  logic              unused_a_hi;

  assign unused_a_hi = ^cpu_a[31:18];

  assign io_sel  = (cpu_a[17:16] == 2'b11);
  assign addr    = cpu_a[ADDR_W-1:0];
  assign off     = cpu_a[3:0];

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rdy_out = !full;
  assign wr_ok   = cpu_wr && rdy_out;

  assign push    = wr_ok && io_sel && (off == OFF_TX);
  assign halt_wr = wr_ok && io_sel && (off == OFF_STAT);
  assign pop     = tx_valid && tx_ready;

  assign tx_valid = !empty;
  // Gate the head with empty so tx_data is a clean 0 whenever nothing is queued.
  assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

  // NOTE: storage arrays carry no reset; contents survive reset and only the
  // pointers/count define what is valid.
  always_ff @(posedge clk_in) begin
    if (wr_ok && !io_sel) ram[addr] <= cpu_dout;
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr] <= cpu_dout;
  end

  // NOTE: all state uses non-blocking assignments so every register sees the
  // pre-edge values of its neighbours.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cpu_din  <= 8'h00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      cnt_snap <= 32'h0;
      cycle_o  <= 32'h0;
      halt_o   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (halt_wr) halt_o <= 1'b1;
      // The halting edge itself must not count, so halt_wr gates it too.
      if (!halt_o && !halt_wr) cycle_o <= cycle_o + 32'd1;

      if (!cpu_wr) begin
        if (!io_sel) begin
          cpu_din <= ram[addr];
        end else begin
          case (off)
            OFF_STAT:  cpu_din <= {6'b0, empty, full};
            OFF_CNT_0: begin
              cpu_din  <= cycle_o[7:0];
              cnt_snap <= cycle_o;
            end
            OFF_CNT_1: cpu_din <= cnt_snap[15:8];
            OFF_CNT_2: cpu_din <= cnt_snap[23:16];
            OFF_CNT_3: cpu_din <= cnt_snap[31:24];
            default:   cpu_din <= 8'h00;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-side responder for the CPU's byte-wide memory bus: answers the core's address/write/data-out signals with one-cycle-latency read data. Holds a byte-addressed RAM and a small I/O region with a character transmit FIFO, a status register, a free-running cycle counter and a halt flag. Instantiated beside the CPU in the system top; its `rdy_out` drives the CPU's `rdy_in`.

## Interface
- `ADDR_W`, 17, RAM address width; RAM depth is 2^ADDR_W bytes
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, at least 2
- `clk_in`  input  1  system clock, all state on rising edge
- `rst_in`  input  1  synchronous, active-low reset
- `cpu_a`  input  32  byte address from CPU; only bits 17:0 decoded
- `cpu_wr`  input  1  1 = write, 0 = read
- `cpu_dout`  input  8  write data from CPU
- `cpu_din`  output  8  read data to CPU, registered
- `rdy_out`  output  1  1 = bus accepts writes; to CPU `rdy_in`
- `tx_data`  output  8  FIFO head byte
- `tx_valid`  output  1  FIFO non-empty
- `tx_ready`  input  1  consumer accepts `tx_data` this cycle
- `halt_o`  output  1  sticky halt flag
- `cycle_o`  output  32  live cycle counter

## Operation
- Decode: `io_sel = (cpu_a[17:16] == 2'b11)`; otherwise RAM at `cpu_a[ADDR_W-1:0]`.
- Write acceptance: a write is accepted only when `cpu_wr=1` and `rdy_out=1`. Writes while `rdy_out=0` are dropped entirely, with no RAM, FIFO or halt effect. The CPU holds the bus until ready.
- RAM write: accepted write with `!io_sel` stores `cpu_dout` at the edge.
- RAM read: when `cpu_wr=0` and `!io_sel`, `cpu_din` loads `ram[addr]` at the edge.
- I/O writes, decoded on `cpu_a[3:0]` inside the region:
  - 0x0 pushes `cpu_dout` into the FIFO.
  - 0x4 sets `halt_o`.
  - Other offsets are ignored.
- I/O reads, loaded into `cpu_din`:
  - 0x0 returns 0x00.
  - 0x4 returns status `{6'b0, empty, full}`.
  - 0x8 returns byte 0 of `cycle_o` and loads `cnt_snap` with the full `cycle_o`.
  - 0x9, 0xA and 0xB return bytes 1, 2 and 3 of `cnt_snap`, so a 4-byte read is coherent.
  - Other offsets return 0x00.
- FIFO: circular buffer with read/write pointers and a count of width clog2(FIFO_DEPTH)+1.
  - `full = (count == FIFO_DEPTH)`; `empty = (count == 0)`.
  - Pop occurs when `tx_valid && tx_ready`.
  - Push and pop in the same cycle leave count unchanged; both pointers advance and wrap modulo FIFO_DEPTH.
  - Push while empty and `tx_ready=1`: the byte becomes head next cycle. There is no bypass.
- `rdy_out = !full`, decoded from the count register. There is no combinational path from bus inputs.
- Counter: `cycle_o` increments by 1 each cycle while `halt_o=0` and wraps from 0xFFFFFFFF to 0. It is frozen once halted.
- `halt_o` clears only on reset.
- Reset (`rst_in=0` at an edge) sets: `cpu_din=0`, FIFO empty (`tx_valid=0`, `rdy_out=1`), `tx_data=0`, `cycle_o=0`, `cnt_snap=0`, `halt_o=0`. RAM contents are not cleared. Reset mid-transfer discards all FIFO contents.

## Timing
- Read latency 1: address presented in cycle N, `cpu_din` valid in N+1 and held until the next read edge. Writes do not change `cpu_din`.
- Read-after-write: a read at the same address in N+1 returns the byte written in N. There is no same-cycle access (one bus op per cycle).
- Push in N: `tx_valid` high in N+1. A push that fills the FIFO drives `rdy_out` low in N+1.
- Pop in N with FIFO full: `rdy_out` high in N+1, so a push can be accepted in N+1.
- Halt write in N: `halt_o=1` in N+1. `cycle_o` does not increment on that edge.
- Status read reflects `full`/`empty` as registered before the read edge.

## Test plan
- Reset, then write 0xA5 to 0x00123, then read 0x00123 next cycle -> `cpu_din=0xA5` one cycle after the read address; `cpu_din=0` right after reset.
- With `tx_ready=0`, push 8 bytes to 0x30000 -> `rdy_out=0` after the 8th push. A 9th write to 0x30000 and a write to 0x00010 are both dropped: FIFO holds 8 entries and RAM[0x10] is unchanged.
- Full FIFO, `tx_ready=1` for 8 cycles -> `tx_data` sequence equals the push order. Status read at 0x30004 returns 0x02 at the end, and returns 0x01 when full.
- Push and pop in the same cycle at count 3, across pointer wrap -> count stays 3 and data order is preserved.
- Read 0x30008..0x3000B on consecutive cycles with the counter near 0x000000FF -> the assembled value equals the snapshot taken at 0x30008, with no byte tearing.
- Write any value to 0x30004 -> `halt_o=1` next cycle and `cycle_o` is frozen. Reset -> `halt_o=0` and `cycle_o=0`.
